// File: rtl/sd_cmd_tx_if.sv
// Handshake and CMD-line signals between the host register file, the SD
// clock divider strobe and the command transmitter.
interface sd_cmd_tx_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] argument;
  logic        bit_en;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;

  modport master (
    output start, cmd_index, argument, bit_en,
    input  cmd_out, cmd_oe, busy, done
  );

  modport slave (
    input  start, cmd_index, argument, bit_en,
    output cmd_out, cmd_oe, busy, done
  );
endinterface

// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: serialises start bit, transmission bit,
// 6-bit index, 32-bit argument, CRC7 and end bit, MSB first, one bit per
// bit_en strobe. All outputs are registered.
module sd_cmd_tx #(
  parameter int          FRAME_BITS = 48,
  parameter logic [6:0]  CRC_POLY   = 7'h09
) (
  input  logic        clk,
  input  logic        rst,
  sd_cmd_tx_if.slave  bus
);

  localparam int         HEAD_BITS = 40;
  // Counter value seen on the strobe that drives the last header bit + 1.
  localparam logic [5:0] HEAD_END  = 6'(HEAD_BITS);
  // Counter value seen on the strobe that drives the end bit.
  localparam logic [5:0] END_IDX   = 6'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_q,   state_d;
  logic [HEAD_BITS-1:0]   shift_q,   shift_d;
  logic [6:0]             crc_q,     crc_d;
  logic [5:0]             cnt_q,     cnt_d;
  logic                   cmd_out_q, cmd_out_d;
  logic                   cmd_oe_q,  cmd_oe_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic                   fb;

  // Next-state, frame sequencing and CRC update.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    cmd_out_d = cmd_out_q;
    cmd_oe_d  = cmd_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fb        = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_oe_d  = 1'b0;
        cmd_out_d = 1'b1;
        busy_d    = 1'b0;
        // A strobe coinciding with the accept is deliberately ignored.
        if (bus.start) begin
          shift_d = {2'b01, bus.cmd_index, bus.argument};
          crc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        if (bus.bit_en) begin
          cnt_d    = cnt_q + 6'd1;
          cmd_oe_d = 1'b1;
          if (cnt_q < HEAD_END) begin
            // Header bit goes out and is folded into the CRC at the same time.
            cmd_out_d = shift_q[HEAD_BITS-1];
            shift_d   = {shift_q[HEAD_BITS-2:0], 1'b0};
            fb        = crc_q[6] ^ shift_q[HEAD_BITS-1];
            crc_d     = {crc_q[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'd0);
          end else if (cnt_q < END_IDX) begin
            // CRC is shifted out MSB first; its low end fills with zeros.
            cmd_out_d = crc_q[6];
            crc_d     = {crc_q[5:0], 1'b0};
          end else begin
            cmd_out_d = 1'b1;
            state_d   = RELEASE;
          end
        end
      end

      RELEASE: begin
        if (bus.bit_en) begin
          cmd_oe_d  = 1'b0;
          cmd_out_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.cmd_out = cmd_out_q;
  assign bus.cmd_oe  = cmd_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: a pulse-counting frame model checked
// every cycle, plus literal frame and reset expectations.
module tb_sd_cmd_tx;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sd_cmd_tx_if bus();

  sd_cmd_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Whole 48-bit frame straight from the protocol definition.
  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    logic [6:0]  crc;
    logic        f;
    head = {2'b01, idx, arg};
    crc  = '0;
    for (int i = 39; i >= 0; i--) begin
      f   = crc[6] ^ head[i];
      crc = {crc[5:0], 1'b0} ^ (f ? 7'h09 : 7'h00);
    end
    return {head, crc, 1'b1};
  endfunction

  // Model: whether a frame is active, how many strobes it has consumed,
  // and the frame being sent.
  logic        m_valid = 1'b0;
  logic        m_active;
  int          m_n;
  logic [47:0] m_frame;
  logic        m_done;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_active <= 1'b0;
      m_n      <= 0;
      m_done   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (bus.start) begin
          m_active <= 1'b1;
          m_n      <= 0;
          m_frame  <= make_frame(bus.cmd_index, bus.argument);
        end
      end else if (bus.bit_en) begin
        if (m_n == 48) begin
          m_active <= 1'b0;
          m_n      <= 0;
          m_done   <= 1'b1;
        end else begin
          m_n <= m_n + 1;
        end
      end
    end
  end

  function automatic logic exp_oe();
    return m_active && (m_n >= 1);
  endfunction

  function automatic logic exp_out();
    return exp_oe() ? m_frame[48 - m_n] : 1'b1;
  endfunction

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmd_out", 64'(bus.cmd_out), 64'(exp_out()));
      check("cmd_oe",  64'(bus.cmd_oe),  64'(exp_oe()));
      check("busy",    64'(bus.busy),    64'(m_active));
      check("done",    64'(bus.done),    64'(m_done));
    end
  end

  // Sends one frame starting at the current negedge. gap_mode 0 = random
  // 1..7 cycle spacing, otherwise a fixed strobe period. disturb pokes start
  // and new inputs mid-frame; abort_after > 0 asserts rst after that strobe.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input int gap_mode, input logic en_at_start,
                           input logic disturb, input int abort_after,
                           input logic [47:0] exp_frame);
    logic [47:0] got;
    int          gap;
    got            = '0;
    bus.start      = 1'b1;
    bus.cmd_index  = idx;
    bus.argument   = arg;
    bus.bit_en     = en_at_start;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      gap = (gap_mode == 0) ? int'($urandom_range(1, 7)) : gap_mode;
      repeat (gap - 1) begin
        bus.bit_en = 1'b0;
        @(negedge clk);
      end
      bus.bit_en = 1'b1;
      @(negedge clk);
      if (k <= 48) got = {got[46:0], bus.cmd_out};
      if (disturb && k == 10) begin
        bus.start     = 1'b1;
        bus.cmd_index = 6'h3F;
        bus.argument  = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
      end
      if (k == abort_after) begin
        rst        = 1'b1;
        bus.bit_en = 1'b0;
        bus.start  = 1'b0;
        @(negedge clk);
        check("abort_cmd_oe",  64'(bus.cmd_oe),  64'd0);
        check("abort_cmd_out", 64'(bus.cmd_out), 64'd1);
        check("abort_busy",    64'(bus.busy),    64'd0);
        check("abort_done",    64'(bus.done),    64'd0);
        rst = 1'b0;
        return;
      end
    end
    bus.bit_en = 1'b0;
    check("frame",      64'(got),      64'(exp_frame));
    check("done_pulse", 64'(bus.done), 64'd1);
    check("busy_end",   64'(bus.busy), 64'd0);
  endtask

  localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_CMD55 = 48'h77_0000_0000_65;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cmd_index = '0;
    bus.argument  = '0;
    bus.bit_en    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_out", 64'(bus.cmd_out), 64'd1);
    check("rst_cmd_oe",  64'(bus.cmd_oe),  64'd0);
    check("rst_busy",    64'(bus.busy),    64'd0);
    check("rst_done",    64'(bus.done),    64'd0);
    rst = 1'b0;

    // Pin the model's frame builder to known-good SD frames.
    check("model_cmd0",  64'(make_frame(6'd0,  32'h0)),       64'(F_CMD0));
    check("model_cmd8",  64'(make_frame(6'd8,  32'h1AA)),     64'(F_CMD8));
    check("model_cmd55", 64'(make_frame(6'd55, 32'h0)),       64'(F_CMD55));

    // Strobes with no frame in flight must do nothing.
    bus.bit_en = 1'b1;
    repeat (5) @(negedge clk);
    bus.bit_en = 1'b0;
    @(negedge clk);

    run_frame(6'd0, 32'h0, 2, 1'b0, 1'b0, 0, F_CMD0);
    repeat (3) @(negedge clk);

    run_frame(6'd8, 32'h1AA, 1, 1'b1, 1'b0, 0, F_CMD8);
    repeat (3) @(negedge clk);

    // Back-to-back: second start lands in the done cycle.
    run_frame(6'd55, 32'h0, 1, 1'b0, 1'b0, 0, F_CMD55);
    run_frame(6'd55, 32'h0, 1, 1'b0, 1'b0, 0, F_CMD55);
    repeat (3) @(negedge clk);

    // Mid-frame start and input changes are ignored.
    run_frame(6'd8, 32'h1AA, 1, 1'b0, 1'b1, 0, F_CMD8);
    repeat (3) @(negedge clk);

    // Reset after the 20th strobe, then a clean CMD0.
    run_frame(6'd8, 32'h1AA, 1, 1'b0, 1'b0, 20, F_CMD8);
    run_frame(6'd0, 32'h0, 2, 1'b0, 1'b0, 0, F_CMD0);
    repeat (3) @(negedge clk);

    // Irregular strobe spacing.
    run_frame(6'd8, 32'h1AA, 0, 1'b0, 1'b0, 0, F_CMD8);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
